// File: rtl/prio_tree_pipe.sv
// prio_tree_pipe: pipelined extreme-value (max or min) index tree.
//
// Each accepted vector is reduced to the index and value of its largest
// (TreePolarity=0) or smallest (TreePolarity=1) enabled leaf. Ties resolve to
// the lowest index. Registers follow every RegStride comparator levels and
// always follow the final level, so the result appears exactly
// ceil(Levels/RegStride) cycles after acceptance. The whole pipeline freezes
// while the output is valid and not taken.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset; clears every stage
//   in_valid   input vector valid
//   in_ready   block can accept a vector this cycle (= ~stall)
//   values     TreeWidth leaf values, unsigned, sampled on acceptance
//   enable     per-leaf participation mask, sampled on acceptance
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_any    at least one leaf was enabled
//   out_idx    winning leaf index (0 when out_any=0)
//   out_val    winning leaf value (0 when out_any=0)
module prio_tree_pipe #(
   parameter int unsigned TreeValWidth = 32,
   parameter int unsigned TreeWidth    = 8,
   parameter bit          TreePolarity = 1'b0,
   parameter int unsigned RegStride    = 1,
   localparam int unsigned Levels       = (TreeWidth > 1) ? $clog2(TreeWidth) : 1,
   localparam int unsigned TreeIdxWidth = Levels
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [TreeValWidth-1:0] values [TreeWidth],
   input  logic [TreeWidth-1:0]    enable,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_any,
   output logic [TreeIdxWidth-1:0] out_idx,
   output logic [TreeValWidth-1:0] out_val
);

   localparam int unsigned NumLeaves = 1 << Levels;

   typedef struct packed {
      logic                    any;
      logic [TreeIdxWidth-1:0] idx;
      logic [TreeValWidth-1:0] val;
   } node_t;

   // Level 0 is the leaf row and is never registered.
   function automatic logic is_reg_level(input int unsigned lvl);
      return (lvl >= 1) && (((lvl % RegStride) == 0) || (lvl == Levels));
   endfunction

   // Ties keep the left child, which makes the lowest index win overall.
   function automatic node_t combine(input node_t left, input node_t right);
      logic right_wins;
      if (!left.any && !right.any) begin
         return '0;
      end
      if (left.any && right.any) begin
         if (TreePolarity == 1'b0) begin
            right_wins = right.val > left.val;
         end else begin
            right_wins = right.val < left.val;
         end
      end else begin
         right_wins = right.any;
      end
      return right_wins ? right : left;
   endfunction

   // tree[l] is the combinational output of level l; stage_q[l] its register.
   // Slots beyond the live width of a level stay zero, and stage_q rows at
   // unregistered levels are never read.
   node_t             tree    [Levels+1][NumLeaves];
   node_t             stage_q [Levels+1][NumLeaves];
   logic [Levels:0]   vcomb;
   logic [Levels:0]   vld_q;
   logic              stall;

   assign out_valid = vld_q[Levels];
   assign stall     = out_valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_any   = stage_q[Levels][0].any;
   assign out_idx   = stage_q[Levels][0].idx;
   assign out_val   = stage_q[Levels][0].val;

   always_comb begin : tree_comb
      node_t left;
      node_t right;
      tree  = '{default: '0};
      vcomb = '0;
      left  = '0;
      right = '0;

      // Disabled and padding leaves are all-zero, so an empty subtree
      // always reduces to {0, 0, 0}.
      vcomb[0] = in_valid;
      for (int unsigned i = 0; i < TreeWidth; i++) begin
         if (enable[i]) begin
            tree[0][i].any = 1'b1;
            tree[0][i].idx = TreeIdxWidth'(i);
            tree[0][i].val = values[i];
         end
      end

      for (int unsigned l = 1; l <= Levels; l++) begin
         vcomb[l] = is_reg_level(l - 1) ? vld_q[l-1] : vcomb[l-1];
         for (int unsigned i = 0; i < (NumLeaves >> l); i++) begin
            if (is_reg_level(l - 1)) begin
               left  = stage_q[l-1][2*i];
               right = stage_q[l-1][2*i+1];
            end else begin
               left  = tree[l-1][2*i];
               right = tree[l-1][2*i+1];
            end
            tree[l][i] = combine(left, right);
         end
      end
   end

   // Every stage holds on stall, bubbles included.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '{default: '0};
         vld_q   <= '0;
      end else if (!stall) begin
         stage_q <= tree;
         vld_q   <= vcomb;
      end
   end

endmodule

// File: tb/tb_prio_tree_pipe.sv
module tb_prio_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   // dut_a: max, W=8, stride 1 (latency 3)
   // dut_b: min, W=8, stride 2 (latency 2)
   // dut_c: max, W=5, stride 1 (latency 3)
   logic [31:0] values8 [8];
   logic [7:0]  enable8;
   logic [31:0] values5 [5];
   logic [4:0]  enable5;

   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_any;
   logic [2:0]  a_out_idx;
   logic [31:0] a_out_val;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_any;
   logic [2:0]  b_out_idx;
   logic [31:0] b_out_val;
   logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_any;
   logic [2:0]  c_out_idx;
   logic [31:0] c_out_val;

   int errors = 0;
   int checks = 0;

   // Min-polarity vectors over values8 = {5,9,3,9,1,0,7,2}
   logic [7:0]  en_tab  [4] = '{8'hFF, 8'hDF, 8'h07, 8'h0A};
   logic [2:0]  exp_idx [4] = '{3'd5, 3'd4, 3'd2, 3'd1};
   logic [31:0] exp_val [4] = '{32'd0, 32'd1, 32'd3, 32'd9};

   prio_tree_pipe #(
      .TreeValWidth(32), .TreeWidth(8), .TreePolarity(1'b0), .RegStride(1)
   ) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .values(values8), .enable(enable8), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_any(a_out_any), .out_idx(a_out_idx),
      .out_val(a_out_val)
   );

   prio_tree_pipe #(
      .TreeValWidth(32), .TreeWidth(8), .TreePolarity(1'b1), .RegStride(2)
   ) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .values(values8), .enable(enable8), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_any(b_out_any), .out_idx(b_out_idx),
      .out_val(b_out_val)
   );

   prio_tree_pipe #(
      .TreeValWidth(32), .TreeWidth(5), .TreePolarity(1'b0), .RegStride(1)
   ) dut_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .values(values5), .enable(enable5), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_any(c_out_any), .out_idx(c_out_idx),
      .out_val(c_out_val)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset a_out_valid: got %0b want 0", a_out_valid);
      end
      checks++;
      if (a_out_any !== 1'b0) begin
         errors++;
         $display("FAIL reset a_out_any: got %0b want 0", a_out_any);
      end
      checks++;
      if (a_out_idx !== 3'd0) begin
         errors++;
         $display("FAIL reset a_out_idx: got %0d want 0", a_out_idx);
      end
      checks++;
      if (a_out_val !== 32'd0) begin
         errors++;
         $display("FAIL reset a_out_val: got %0h want 0", a_out_val);
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset a_in_ready: got %0b want 1", a_in_ready);
      end
      checks++;
      if ({b_out_valid, b_in_ready, c_out_valid, c_in_ready} !== 4'b0101) begin
         errors++;
         $display("FAIL reset b/c valid,ready: got %b want 0101",
                  {b_out_valid, b_in_ready, c_out_valid, c_in_ready});
      end
   endtask

   task automatic test_max_basic;
      enable8    = 8'hFF;
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      enable8    = 8'h00;  // must not affect the in-flight vector
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL max early out_valid: got %0b want 0", a_out_valid);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL max out_valid: got %0b want 1", a_out_valid);
      end
      checks++;
      if (a_out_any !== 1'b1) begin
         errors++;
         $display("FAIL max out_any: got %0b want 1", a_out_any);
      end
      checks++;
      if (a_out_idx !== 3'd1) begin
         errors++;
         $display("FAIL max tie out_idx: got %0d want 1", a_out_idx);
      end
      checks++;
      if (a_out_val !== 32'd9) begin
         errors++;
         $display("FAIL max out_val: got %0d want 9", a_out_val);
      end
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL max bubble out_valid: got %0b want 0", a_out_valid);
      end
   endtask

   task automatic test_min_mask;
      enable8    = 8'hDF;
      b_in_valid = 1'b1;
      tick();
      enable8 = 8'h00;
      tick();
      b_in_valid = 1'b0;
      checks++;
      if ({b_out_valid, b_out_any, b_out_idx, b_out_val} !== {1'b1, 1'b1, 3'd4, 32'd1}) begin
         errors++;
         $display("FAIL min masked: got v=%0b any=%0b idx=%0d val=%0d want v=1 any=1 idx=4 val=1",
                  b_out_valid, b_out_any, b_out_idx, b_out_val);
      end
      tick();
      checks++;
      if ({b_out_valid, b_out_any, b_out_idx, b_out_val} !== {1'b1, 1'b0, 3'd0, 32'd0}) begin
         errors++;
         $display("FAIL min empty mask: got v=%0b any=%0b idx=%0d val=%0d want v=1 any=0 idx=0 val=0",
                  b_out_valid, b_out_any, b_out_idx, b_out_val);
      end
      tick();
      checks++;
      if (b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL min drained out_valid: got %0b want 0", b_out_valid);
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 4; k++) begin
         enable8    = en_tab[k];
         b_in_valid = 1'b1;
         tick();
         if (k > 0) begin
            checks++;
            if ({b_out_valid, b_out_any, b_out_idx, b_out_val} !==
                {1'b1, 1'b1, exp_idx[k-1], exp_val[k-1]}) begin
               errors++;
               $display("FAIL b2b vec%0d: got v=%0b idx=%0d val=%0d want v=1 idx=%0d val=%0d",
                        k - 1, b_out_valid, b_out_idx, b_out_val, exp_idx[k-1], exp_val[k-1]);
            end
         end
      end
      b_in_valid = 1'b0;
      tick();
      checks++;
      if ({b_out_valid, b_out_any, b_out_idx, b_out_val} !== {1'b1, 1'b1, exp_idx[3], exp_val[3]}) begin
         errors++;
         $display("FAIL b2b vec3: got v=%0b idx=%0d val=%0d want v=1 idx=%0d val=%0d",
                  b_out_valid, b_out_idx, b_out_val, exp_idx[3], exp_val[3]);
      end
      tick();
      checks++;
      if (b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b gap after stream: got %0b want 0", b_out_valid);
      end
   endtask

   task automatic test_stall;
      b_out_ready = 1'b0;
      enable8     = en_tab[0];
      b_in_valid  = 1'b1;
      tick();
      enable8 = en_tab[1];
      tick();
      enable8 = en_tab[2];  // presented but blocked while stalled
      checks++;
      if ({b_out_valid, b_out_idx, b_out_val, b_in_ready} !== {1'b1, exp_idx[0], exp_val[0], 1'b0}) begin
         errors++;
         $display("FAIL stall entry: got v=%0b idx=%0d val=%0d rdy=%0b want v=1 idx=%0d val=%0d rdy=0",
                  b_out_valid, b_out_idx, b_out_val, b_in_ready, exp_idx[0], exp_val[0]);
      end
      for (int h = 0; h < 5; h++) begin
         tick();
         checks++;
         if ({b_out_valid, b_out_any, b_out_idx, b_out_val, b_in_ready} !==
             {1'b1, 1'b1, exp_idx[0], exp_val[0], 1'b0}) begin
            errors++;
            $display("FAIL stall hold %0d: got v=%0b idx=%0d val=%0d rdy=%0b want v=1 idx=%0d val=%0d rdy=0",
                     h, b_out_valid, b_out_idx, b_out_val, b_in_ready, exp_idx[0], exp_val[0]);
         end
      end
      b_out_ready = 1'b1;
      #1;
      checks++;
      if (b_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall release in_ready: got %0b want 1", b_in_ready);
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         if (k == 1) enable8 = en_tab[3];
         if (k == 2) b_in_valid = 1'b0;
         checks++;
         if ({b_out_valid, b_out_idx, b_out_val} !== {1'b1, exp_idx[k], exp_val[k]}) begin
            errors++;
            $display("FAIL stall drain vec%0d: got v=%0b idx=%0d val=%0d want v=1 idx=%0d val=%0d",
                     k, b_out_valid, b_out_idx, b_out_val, exp_idx[k], exp_val[k]);
         end
      end
      tick();
      checks++;
      if (b_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall drain extra: got out_valid=%0b want 0", b_out_valid);
      end
   endtask

   task automatic test_nonpow2;
      enable5    = 5'h1F;
      c_in_valid = 1'b1;
      tick();
      enable5 = 5'h0F;
      tick();
      c_in_valid = 1'b0;
      checks++;
      if (c_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL w5 early out_valid: got %0b want 0", c_out_valid);
      end
      tick();
      checks++;
      if ({c_out_valid, c_out_any, c_out_idx, c_out_val} !== {1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL w5 full mask: got v=%0b any=%0b idx=%0d val=%0h want v=1 any=1 idx=4 val=ffffffff",
                  c_out_valid, c_out_any, c_out_idx, c_out_val);
      end
      tick();
      checks++;
      if ({c_out_valid, c_out_any, c_out_idx, c_out_val} !== {1'b1, 1'b1, 3'd3, 32'd4}) begin
         errors++;
         $display("FAIL w5 mask 0f: got v=%0b any=%0b idx=%0d val=%0h want v=1 any=1 idx=3 val=4",
                  c_out_valid, c_out_any, c_out_idx, c_out_val);
      end
   endtask

   task automatic test_reset_flush;
      enable8    = 8'hFF;
      a_in_valid = 1'b1;
      tick();
      enable8 = 8'h01;
      tick();
      a_in_valid = 1'b0;
      reset      = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({a_out_valid, a_in_ready, a_out_val} !== {1'b0, 1'b1, 32'd0}) begin
         errors++;
         $display("FAIL flush after reset: got v=%0b rdy=%0b val=%0h want v=0 rdy=1 val=0",
                  a_out_valid, a_in_ready, a_out_val);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush stale result %0d: got out_valid=%0b want 0", k, a_out_valid);
         end
      end
      enable8    = 8'h44;  // leaves 2 and 6: values 3 and 7
      a_in_valid = 1'b1;
      tick();
      a_in_valid = 1'b0;
      tick();
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush post-reset early: got out_valid=%0b want 0", a_out_valid);
      end
      tick();
      checks++;
      if ({a_out_valid, a_out_any, a_out_idx, a_out_val} !== {1'b1, 1'b1, 3'd6, 32'd7}) begin
         errors++;
         $display("FAIL flush post-reset vec: got v=%0b any=%0b idx=%0d val=%0d want v=1 any=1 idx=6 val=7",
                  a_out_valid, a_out_any, a_out_idx, a_out_val);
      end
   endtask

   initial begin
      reset       = 1'b1;
      values8     = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0, 32'd7, 32'd2};
      enable8     = 8'h00;
      values5     = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hFFFF_FFFF};
      enable5     = 5'h00;
      a_in_valid  = 1'b0;
      b_in_valid  = 1'b0;
      c_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      c_out_ready = 1'b1;

      test_reset();
      test_max_basic();
      test_min_mask();
      test_back_to_back();
      test_stall();
      test_nonpow2();
      test_reset_flush();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want normal finish");
      $fatal(1, "watchdog expired");
   end

endmodule
